// File: rtl/wait_event_sched_tb.sv
// Round-robin scheduler that shares one wait_event_tb instance between REQ_NB requesters.
// Optional abort path is compiled in when WAIT_SCHED_ABORT_EN is defined.
module wait_event_sched_tb #(
    parameter int REQ_NB    = 4,
    parameter int WAIT_SIZE = 5,
    parameter int IDX_WIDTH = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [REQ_NB-1:0]                    i_req,
    input  logic [REQ_NB-1:0]                    i_req_edge,
    input  logic [REQ_NB-1:0][IDX_WIDTH-1:0]     i_req_idx,
    input  logic [REQ_NB-1:0][31:0]              i_req_timeout,
    output logic [REQ_NB-1:0]                    o_gnt,
    output logic [REQ_NB-1:0]                    o_ack,
    output logic                                 o_status_timeout,
    output logic                                 o_status_err,
`ifdef WAIT_SCHED_ABORT_EN
    input  logic                                 i_abort,
    output logic                                 o_status_abort,
`endif
    output logic                                 o_busy,
    output logic                                 o_en_wait_event,
    output logic [IDX_WIDTH-1:0]                 o_wait_idx,
    output logic                                 o_sel_wtr_wtf,
    output logic [31:0]                          o_max_timeout,
    input  logic                                 i_wait_done
);

    localparam int          PTR_W       = (REQ_NB > 1) ? $clog2(REQ_NB) : 1;
    localparam logic [31:0] WAIT_SIZE_W = 32'(WAIT_SIZE);

    typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

    state_t                 state_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [31:0]            cnt_q;
    logic [REQ_NB-1:0]      gnt_q;
    logic [REQ_NB-1:0]      ack_q;
    logic                   status_timeout_q;
    logic                   status_err_q;
    logic                   busy_q;
    logic                   en_q;
    logic [IDX_WIDTH-1:0]   wait_idx_q;
    logic                   sel_q;
    logic [31:0]            max_timeout_q;
`ifdef WAIT_SCHED_ABORT_EN
    logic                   status_abort_q;
`endif

    logic                   win_vld_d;
    logic [PTR_W-1:0]       win_d;
    logic [IDX_WIDTH-1:0]   win_idx_d;
    logic                   idx_err_d;
    logic [REQ_NB-1:0]      win_onehot_d;

    function automatic logic [PTR_W-1:0] rr_pos(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % REQ_NB;
        return s[PTR_W-1:0];
    endfunction

    // Scan downward so the position closest to the pointer is written last and wins.
    always_comb begin
        win_vld_d = 1'b0;
        win_d     = '0;
        for (int k = REQ_NB - 1; k >= 0; k--) begin
            if (i_req[rr_pos(ptr_q, k)]) begin
                win_vld_d = 1'b1;
                win_d     = rr_pos(ptr_q, k);
            end
        end
    end

    assign win_idx_d    = i_req_idx[win_d];
    assign idx_err_d    = 32'(win_idx_d) >= WAIT_SIZE_W;
    assign win_onehot_d = {{(REQ_NB-1){1'b0}}, 1'b1} << win_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            ptr_q            <= '0;
            cnt_q            <= '0;
            gnt_q            <= '0;
            ack_q            <= '0;
            status_timeout_q <= 1'b0;
            status_err_q     <= 1'b0;
            busy_q           <= 1'b0;
            en_q             <= 1'b0;
            wait_idx_q       <= '0;
            sel_q            <= 1'b0;
            max_timeout_q    <= '0;
`ifdef WAIT_SCHED_ABORT_EN
            status_abort_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        gnt_q  <= win_onehot_d;
                        ptr_q  <= rr_pos(win_d, 1);
                        busy_q <= 1'b1;
                        if (idx_err_d) begin
                            ack_q        <= win_onehot_d;
                            status_err_q <= 1'b1;
                            state_q      <= RELEASE;
                        end else begin
                            en_q          <= 1'b1;
                            wait_idx_q    <= win_idx_d;
                            sel_q         <= i_req_edge[win_d];
                            max_timeout_q <= i_req_timeout[win_d];
                            cnt_q         <= '0;
                            state_q       <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q != 32'hFFFF_FFFF) begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                    if (i_wait_done) begin
                        en_q             <= 1'b0;
                        ack_q            <= gnt_q;
                        status_timeout_q <= (max_timeout_q != 32'd0) && (cnt_q > max_timeout_q);
                        state_q          <= RELEASE;
                    end
`ifdef WAIT_SCHED_ABORT_EN
                    else if (i_abort) begin
                        en_q           <= 1'b0;
                        ack_q          <= gnt_q;
                        status_abort_q <= 1'b1;
                        state_q        <= RELEASE;
                    end
`endif
                end
                // Ack cycle; together with the following IDLE cycle the enable is low for two cycles.
                RELEASE: begin
                    gnt_q            <= '0;
                    ack_q            <= '0;
                    status_timeout_q <= 1'b0;
                    status_err_q     <= 1'b0;
                    busy_q           <= 1'b0;
                    wait_idx_q       <= '0;
                    sel_q            <= 1'b0;
                    max_timeout_q    <= '0;
`ifdef WAIT_SCHED_ABORT_EN
                    status_abort_q   <= 1'b0;
`endif
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt            = gnt_q;
    assign o_ack            = ack_q;
    assign o_status_timeout = status_timeout_q;
    assign o_status_err     = status_err_q;
    assign o_busy           = busy_q;
    assign o_en_wait_event  = en_q;
    assign o_wait_idx       = wait_idx_q;
    assign o_sel_wtr_wtf    = sel_q;
    assign o_max_timeout    = max_timeout_q;
`ifdef WAIT_SCHED_ABORT_EN
    assign o_status_abort   = status_abort_q;
`endif

endmodule

// File: tb/tb_wait_event_sched_tb.sv
// Bench for wait_event_sched_tb: vector table plus round-robin, reset and abort sequences.
module tb_wait_event_sched_tb;

    localparam int REQ_NB    = 4;
    localparam int WAIT_SIZE = 5;
    localparam int IDX_WIDTH = 3;

    logic                             clk = 1'b0;
    logic                             rst_n = 1'b0;
    logic [REQ_NB-1:0]                req = '0;
    logic [REQ_NB-1:0]                req_edge = '0;
    logic [REQ_NB-1:0][IDX_WIDTH-1:0] req_idx = '0;
    logic [REQ_NB-1:0][31:0]          req_to = '0;
    logic                             done = 1'b0;
    logic [REQ_NB-1:0]                o_gnt, o_ack;
    logic                             o_status_timeout, o_status_err, o_busy, o_en, o_sel;
    logic [IDX_WIDTH-1:0]             o_wait_idx;
    logic [31:0]                      o_max_to;
`ifdef WAIT_SCHED_ABORT_EN
    logic                             abort = 1'b0;
    logic                             o_status_abort;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   id;
        logic err;
        logic tmo;
        logic ab;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          id;
        logic        edge_f;
        logic [2:0]  idx;
        logic [31:0] to;
        int          k;
        logic        exp_err;
        logic        exp_tmo;
    } vec_t;
    vec_t vt[8];

    wait_event_sched_tb #(.REQ_NB(REQ_NB), .WAIT_SIZE(WAIT_SIZE), .IDX_WIDTH(IDX_WIDTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req            (req),
        .i_req_edge       (req_edge),
        .i_req_idx        (req_idx),
        .i_req_timeout    (req_to),
        .o_gnt            (o_gnt),
        .o_ack            (o_ack),
        .o_status_timeout (o_status_timeout),
        .o_status_err     (o_status_err),
`ifdef WAIT_SCHED_ABORT_EN
        .i_abort          (abort),
        .o_status_abort   (o_status_abort),
`endif
        .o_busy           (o_busy),
        .o_en_wait_event  (o_en),
        .o_wait_idx       (o_wait_idx),
        .o_sel_wtr_wtf    (o_sel),
        .o_max_timeout    (o_max_to),
        .i_wait_done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic wait_ack_and_score();
        int   waited = 0;
        exp_t e;
        while (o_ack == '0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (o_ack == '0 || sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_wait: ack=%0h queued=%0d, expected an ack for a queued command",
                     o_ack, sb.size());
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check("ack_id", 64'(o_ack), 64'(1) << e.id);
        check("gnt_at_ack", 64'(o_gnt), 64'(1) << e.id);
        check("status_err", 64'(o_status_err), 64'(e.err));
        check("status_timeout", 64'(o_status_timeout), 64'(e.tmo));
        check("en_at_ack", 64'(o_en), 64'(0));
`ifdef WAIT_SCHED_ABORT_EN
        check("status_abort", 64'(o_status_abort), 64'(e.ab));
`endif
        req[e.id] = 1'b0;
    endtask

    // Done is raised on the k-th cycle the enable is visible, so the counter holds k-1 when it is sampled.
    task automatic run_vec(input vec_t v);
        req_edge[v.id] = v.edge_f;
        req_idx[v.id]  = v.idx;
        req_to[v.id]   = v.to;
        req[v.id]      = 1'b1;
        sb.push_back('{v.id, v.exp_err, v.exp_tmo, 1'b0});
        @(negedge clk);
        check("gnt_issue", 64'(o_gnt), 64'(1) << v.id);
        check("busy_issue", 64'(o_busy), 64'(1));
        check("en_issue", 64'(o_en), 64'(!v.exp_err));
        if (!v.exp_err) begin
            check("wait_idx", 64'(o_wait_idx), 64'(v.idx));
            check("sel_wtr_wtf", 64'(o_sel), 64'(v.edge_f));
            check("max_timeout", 64'(o_max_to), 64'(v.to));
            repeat (v.k - 1) @(negedge clk);
            check("en_held", 64'(o_en), 64'(1));
            check("no_early_ack", 64'(o_ack), 64'(0));
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
        end
        wait_ack_and_score();
        @(negedge clk);
        check("idle_gnt", 64'(o_gnt), 64'(0));
        check("idle_busy", 64'(o_busy), 64'(0));
        check("idle_en", 64'(o_en), 64'(0));
    endtask

    // Serves queued expectations in order while all requesters in mask stay pending.
    task automatic serve(input logic [REQ_NB-1:0] mask, input int n);
        int gap = 0;
        int waited;
        req = mask;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (!o_en && waited < 20) begin
                @(negedge clk);
                waited++;
                if (!o_en) gap++;
            end
            if (!o_en || sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL serve_issue: en=%0b queued=%0d, expected an issued command", o_en, sb.size());
                req = '0;
                return;
            end
            if (i > 0) check("enable_gap", 64'(gap), 64'(2));
            check("rr_gnt", 64'(o_gnt), 64'(1) << sb[0].id);
            @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            wait_ack_and_score();
            gap = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        vt[0] = '{0, 1'b0, 3'd2, 32'd100, 10, 1'b0, 1'b0};
        vt[1] = '{1, 1'b1, 3'd4, 32'd20,  22, 1'b0, 1'b1};
        vt[2] = '{2, 1'b0, 3'd7, 32'd5,   1,  1'b1, 1'b0};
        vt[3] = '{3, 1'b0, 3'd0, 32'd5,   6,  1'b0, 1'b0};
        vt[4] = '{3, 1'b1, 3'd1, 32'd5,   7,  1'b0, 1'b1};
        vt[5] = '{0, 1'b0, 3'd3, 32'd0,   40, 1'b0, 1'b0};
        vt[6] = '{2, 1'b1, 3'd5, 32'd10,  3,  1'b1, 1'b0};
        vt[7] = '{1, 1'b0, 3'd4, 32'd1,   3,  1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_gnt", 64'(o_gnt), 64'(0));
        check("rst_ack", 64'(o_ack), 64'(0));
        check("rst_en", 64'(o_en), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_max_to", 64'(o_max_to), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        check("idle_done_no_ack", 64'(o_ack), 64'(0));
        check("idle_done_not_busy", 64'(o_busy), 64'(0));

        req_idx[2] = 3'd1;
        req_to[2]  = 32'd77;
        req[2]     = 1'b1;
        @(negedge clk);
        check("pre_rst_en", 64'(o_en), 64'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_en", 64'(o_en), 64'(0));
        check("midrst_gnt", 64'(o_gnt), 64'(0));
        check("midrst_busy", 64'(o_busy), 64'(0));
        check("midrst_max_to", 64'(o_max_to), 64'(0));
        check("midrst_idx", 64'(o_wait_idx), 64'(0));
        req   = '0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("postrst_no_ack", 64'(o_ack), 64'(0));
        end

        for (int i = 0; i < REQ_NB; i++) begin
            req_idx[i]  = 3'(i);
            req_to[i]   = 32'd0;
            req_edge[i] = 1'(i % 2);
            sb.push_back('{i, 1'b0, 1'b0, 1'b0});
        end
        serve(4'b1111, 4);
        sb.push_back('{0, 1'b0, 1'b0, 1'b0});
        sb.push_back('{3, 1'b0, 1'b0, 1'b0});
        serve(4'b1001, 2);

`ifdef WAIT_SCHED_ABORT_EN
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_no_ack", 64'(o_ack), 64'(0));
        req_idx[0] = 3'd1;
        req_to[0]  = 32'd0;
        req[0]     = 1'b1;
        sb.push_back('{0, 1'b0, 1'b0, 1'b1});
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_ack_and_score();
        @(negedge clk);
        req[0] = 1'b1;
        sb.push_back('{0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        done  = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        done  = 1'b0;
        abort = 1'b0;
        wait_ack_and_score();
        @(negedge clk);
`endif

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
